mdio_responder: RTL and testbench
=================================

MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1: Clause-22 PHY address this block answers to.
REQ-002 Parameter PHYID1, default 16'h0022: value of read-only register 2.
REQ-003 Parameter PHYID2, default 16'h5F10: value of read-only register 3.
REQ-004 Parameter PRE_LEN, default 32: consecutive ones required as preamble.
REQ-005 Clock and reset: single clock CLK; reset RST_N is asynchronous and active-low.
REQ-006 CLK  in  1  system clock; SHALL be at least 4x the MDC frequency.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 mdc_i  in  1  MDIO management clock from the initiator (asynchronous to CLK).
REQ-009 mdd_i  in  1  MDIO data pin input.
REQ-010 mdd_o  out  1  MDIO data driven by the responder.
REQ-011 mdd_oe  out  1  tristate enable for mdd_o (1 = drive).
REQ-012 loc_we  in  1  local register write strobe.
REQ-013 loc_addr  in  5  local write register address.
REQ-014 loc_wdata  in  16  local write data.
REQ-015 wr_valid  out  1  one-CLK pulse on a completed MDIO write.
REQ-016 wr_addr  out  5  register address of the completed MDIO write.
REQ-017 wr_data  out  16  data of the completed MDIO write.
REQ-018 frame_err  out  1  one-CLK pulse on an aborted frame.

Function
REQ-019 mdc_i and mdd_i SHALL pass through 2-flop synchronizers; an MDC rising edge is detected from a third flop; all protocol actions occur on the CLK cycle of edge detect ("MDC tick").
REQ-020 mdd_i SHALL be sampled on MDC ticks only; mdd_o/mdd_oe SHALL change only on MDC ticks, 3 CLK cycles after the pin edge.
REQ-021 FSM states: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP.
REQ-022 IDLE: count consecutive sampled ones (saturating at PRE_LEN); a zero with count < PRE_LEN clears the count; a zero with count = PRE_LEN -> ST.
REQ-023 ST: sample 1 -> OP; sample 0 -> IDLE with frame_err pulse.
REQ-024 OP: two bits MSB first; 10 = read, 01 = write; 00/11 -> frame_err, IDLE.
REQ-025 PHYAD: 5 bits MSB first, then REGAD: 5 bits MSB first; bit counter reloads per field.
REQ-026 PHYAD != PHY_ADDR: after REGAD -> SKIP for 18 ticks, then IDLE; mdd_oe stays 0; no frame_err.
REQ-027 Read, address match: the tick sampling TA bit 1 SHALL set mdd_oe=1, mdd_o=0; the next 16 ticks drive register bits 15..0; the following tick clears mdd_oe and returns to IDLE.
REQ-028 Write, address match: TA bits sampled SHALL equal 1,0, else frame_err and IDLE; then 16 bits MSB first enter WDATA shift register.
REQ-029 On the 16th write data tick: registers 2 and 3 unchanged, otherwise register written; wr_valid pulses one CLK with wr_addr/wr_data (pulse also for registers 2/3); -> IDLE.
REQ-030 Register file: 32 x 16; registers 2/3 read PHYID1/PHYID2 constants; all others reset to 16'h0000.
REQ-031 loc_we writes loc_wdata to loc_addr on the same CLK edge; writes to 2/3 ignored.
REQ-032 Simultaneous MDIO and local write to the same address: MDIO write wins; different addresses: both take effect.
REQ-033 Read data SHALL be captured into the output shift register on the TA-bit-1 tick; later writes do not alter the frame in progress.
REQ-034 Preamble count after a frame SHALL restart at 0; frames need a full new preamble (no preamble suppression).
REQ-035 Loss of MDC mid-frame: block SHALL hold state indefinitely (no timeout).

Reset
REQ-036 RST_N low SHALL immediately force mdd_oe=0, mdd_o=0, wr_valid=0, frame_err=0, wr_addr=0, wr_data=0, FSM=IDLE, preamble count=0, synchronizers=0, and registers to their reset values.
REQ-037 Reset asserted mid-read SHALL release the bus asynchronously, before the next CLK edge.

Verification
REQ-038 32 ones, write PHYAD 1 REGAD 4 TA 10 data 16'hA5C3 -> wr_valid one cycle, wr_addr=4, wr_data=16'hA5C3; subsequent read of reg 4 returns 16'hA5C3, mdd_oe high for exactly 17 ticks.
REQ-039 Read PHYAD 1 REGAD 2 -> TA bit 2 = 0, data 16'h0022; REGAD 3 -> 16'h5F10; write 16'hFFFF to reg 2 -> wr_valid pulses, reread still 16'h0022.
REQ-040 31 ones then 0,1 start -> no response, no frame_err; 32 ones, ST 00 -> frame_err pulse, mdd_oe never asserted.
REQ-041 Read PHYAD 7 -> mdd_oe stays 0; next well-formed read to PHYAD 1 after SKIP completes answers correctly.
REQ-042 Same-cycle loc_we (addr 5, 16'h1111) and MDIO write completion (addr 5, 16'h2222) -> reg 5 = 16'h2222; repeat with loc_addr 6 -> reg 6 = 16'h1111.
REQ-043 RST_N asserted at read data bit 8 -> mdd_oe=0 within the same CLK cycle; after release, a full new frame is answered correctly.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side) with a 32 x 16 register file and a local write port.
// Latency: pins are synchronized (2 flops + edge flop), so every protocol action lands 3 CLK after an MDC rising edge.
// Backpressure: none; MDIO is paced by the initiator's MDC, and local writes are accepted every CLK.
//
// Ports:
//   CLK, RST_N          system clock (>= 4x MDC) and asynchronous active-low reset
//   mdc_i, mdd_i        MDIO clock / data from the pin (asynchronous to CLK)
//   mdd_o, mdd_oe       MDIO data and tristate enable driven back to the pin
//   loc_we/addr/wdata   local register write port (registers 2/3 are read-only)
//   wr_valid/addr/data  one-CLK notification of a completed MDIO write
//   frame_err           one-CLK pulse when a frame is aborted on a malformed field
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHYID1   = 16'h0022,
  parameter logic [15:0] PHYID2   = 16'h5F10,
  parameter int          PRE_LEN  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        mdc_i,
  input  logic        mdd_i,
  output logic        mdd_o,
  output logic        mdd_oe,
  input  logic        loc_we,
  input  logic [4:0]  loc_addr,
  input  logic [15:0] loc_wdata,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam int            PW      = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. mdc_sync[2] is the edge-detect flop; tick is high for
  // exactly one CLK per MDC rising edge, and the sampled data bit is taken from
  // the matching stage of the data synchronizer.
  // ---------------------------------------------------------------------------
  logic [2:0] mdc_sync;
  logic [1:0] mdd_sync;
  logic       tick;
  logic       sbit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mdc_sync <= 3'b000;
      mdd_sync <= 2'b00;
    end else begin
      mdc_sync <= {mdc_sync[1:0], mdc_i};
      mdd_sync <= {mdd_sync[0], mdd_i};
    end
  end

  assign tick = mdc_sync[1] & ~mdc_sync[2];
  assign sbit = mdd_sync[1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t        state,    state_n;
  logic [4:0]    bit_cnt,  bit_cnt_n;
  logic [PW-1:0] pre_cnt,  pre_cnt_n;
  logic          bit_hold, bit_hold_n;   // first bit of the two-bit OP / TA fields
  logic          is_rd,    is_rd_n;
  logic [4:0]    phyad,    phyad_n;
  logic [4:0]    regad,    regad_n;
  logic [15:0]   rd_sh,    rd_sh_n;
  logic [15:0]   wr_sh,    wr_sh_n;
  logic          mdd_o_n,  mdd_oe_n;
  logic          wr_valid_n, frame_err_n;
  logic [4:0]    wr_addr_n;
  logic [15:0]   wr_data_n;
  logic          mdio_we;
  logic [15:0]   rd_val;

  logic [15:0]   regs [32];

  // Registers 2/3 are constants; every other address comes from storage.
  always_comb begin
    case (regad)
      5'd2:    rd_val = PHYID1;
      5'd3:    rd_val = PHYID2;
      default: rd_val = regs[regad];
    endcase
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    pre_cnt_n   = pre_cnt;
    bit_hold_n  = bit_hold;
    is_rd_n     = is_rd;
    phyad_n     = phyad;
    regad_n     = regad;
    rd_sh_n     = rd_sh;
    wr_sh_n     = wr_sh;
    mdd_o_n     = mdd_o;
    mdd_oe_n    = mdd_oe;
    wr_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    mdio_we     = 1'b0;

    if (tick) begin
      case (state)
        IDLE: begin
          if (sbit) begin
            if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 1'b1;
          end else begin
            // This zero is the first start bit when the preamble is complete.
            pre_cnt_n = '0;
            if (pre_cnt == PRE_MAX) state_n = ST;
          end
        end

        ST: begin
          if (sbit) begin
            state_n   = OP;
            bit_cnt_n = 5'd0;
          end else begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
          end
        end

        OP: begin
          if (bit_cnt == 5'd0) begin
            bit_hold_n = sbit;
            bit_cnt_n  = 5'd1;
          end else begin
            bit_cnt_n = 5'd0;
            if ({bit_hold, sbit} == 2'b10) begin
              is_rd_n = 1'b1;
              state_n = PHYAD;
            end else if ({bit_hold, sbit} == 2'b01) begin
              is_rd_n = 1'b0;
              state_n = PHYAD;
            end else begin
              state_n     = IDLE;
              frame_err_n = 1'b1;
            end
          end
        end

        PHYAD: begin
          phyad_n = {phyad[3:0], sbit};
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = 5'd0;
            state_n   = REGAD;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        REGAD: begin
          regad_n = {regad[3:0], sbit};
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = 5'd0;
            // Another PHY owns this frame: let its TA + data go by silently.
            state_n   = (phyad == PHY_ADDR) ? TA : SKIP;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        TA: begin
          if (is_rd) begin
            // Take the bus on TA bit 1 and snapshot the register so that
            // writes landing during the frame cannot tear the read data.
            mdd_oe_n  = 1'b1;
            mdd_o_n   = 1'b0;
            rd_sh_n   = rd_val;
            bit_cnt_n = 5'd0;
            state_n   = RDATA;
          end else if (bit_cnt == 5'd0) begin
            bit_hold_n = sbit;
            bit_cnt_n  = 5'd1;
          end else begin
            bit_cnt_n = 5'd0;
            if ({bit_hold, sbit} == 2'b10) begin
              state_n = WDATA;
            end else begin
              state_n     = IDLE;
              frame_err_n = 1'b1;
            end
          end
        end

        RDATA: begin
          // 16 ticks shift out bits 15..0, the 17th releases the bus.
          if (bit_cnt == 5'd16) begin
            mdd_oe_n  = 1'b0;
            mdd_o_n   = 1'b0;
            bit_cnt_n = 5'd0;
            state_n   = IDLE;
          end else begin
            mdd_o_n   = rd_sh[15];
            rd_sh_n   = {rd_sh[14:0], 1'b0};
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        WDATA: begin
          wr_sh_n = {wr_sh[14:0], sbit};
          if (bit_cnt == 5'd15) begin
            wr_valid_n = 1'b1;
            wr_addr_n  = regad;
            wr_data_n  = {wr_sh[14:0], sbit};
            mdio_we    = (regad != 5'd2) && (regad != 5'd3);
            bit_cnt_n  = 5'd0;
            state_n    = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        SKIP: begin
          // Two TA bits plus 16 data bits.
          if (bit_cnt == 5'd17) begin
            bit_cnt_n = 5'd0;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      pre_cnt   <= '0;
      bit_hold  <= 1'b0;
      is_rd     <= 1'b0;
      phyad     <= 5'd0;
      regad     <= 5'd0;
      rd_sh     <= 16'h0000;
      wr_sh     <= 16'h0000;
      mdd_o     <= 1'b0;
      mdd_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 16'h0000;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      pre_cnt   <= pre_cnt_n;
      bit_hold  <= bit_hold_n;
      is_rd     <= is_rd_n;
      phyad     <= phyad_n;
      regad     <= regad_n;
      rd_sh     <= rd_sh_n;
      wr_sh     <= wr_sh_n;
      mdd_o     <= mdd_o_n;
      mdd_oe    <= mdd_oe_n;
      wr_valid  <= wr_valid_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      frame_err <= frame_err_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The MDIO write is issued after the local write so that a
  // same-address collision resolves in favour of MDIO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) regs[i] <= 16'h0000;
    end else begin
      if (loc_we && (loc_addr != 5'd2) && (loc_addr != 5'd3))
        regs[loc_addr] <= loc_wdata;
      if (mdio_we)
        regs[regad] <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder: drives whole MDIO frames bit by bit,
// predicts bus behaviour and write notifications from a frame-level model.
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'd1;
  localparam int         PRE = 32;

  logic        CLK       = 1'b0;
  logic        RST_N     = 1'b0;
  logic        mdc_i     = 1'b0;
  logic        mdd_i     = 1'b1;
  logic        loc_we    = 1'b0;
  logic [4:0]  loc_addr  = 5'd0;
  logic [15:0] loc_wdata = 16'h0000;
  logic        mdd_o, mdd_oe, wr_valid, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Event counters kept by the monitor; the stimulus thread diffs snapshots.
  int          wv_cnt = 0;
  int          fe_cnt = 0;
  int          oe_cyc = 0;
  logic [4:0]  wa_cap = 5'd0;
  logic [15:0] wd_cap = 16'h0000;

  logic [15:0] model_reg [32];

  always #5 CLK = ~CLK;

  mdio_responder #(
    .PHY_ADDR (5'd1),
    .PHYID1   (16'h0022),
    .PHYID2   (16'h5F10),
    .PRE_LEN  (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .mdc_i     (mdc_i),
    .mdd_i     (mdd_i),
    .mdd_o     (mdd_o),
    .mdd_oe    (mdd_oe),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always @(negedge CLK) begin
    if (wr_valid) begin
      wv_cnt = wv_cnt + 1;
      wa_cap = wr_addr;
      wd_cap = wr_data;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (mdd_oe)    oe_cyc = oe_cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [4:0] a);
    if (a == 5'd2) return 16'h0022;
    if (a == 5'd3) return 16'h5F10;
    return model_reg[a];
  endfunction

  // One MDIO frame: npre ones, ST, OP, PHYAD, REGAD, TA, 16 data bits, one idle 0.
  // loc_at: bit index whose tick coincides with a local write (-1 = none).
  // rst_at: bit index at which reset is asserted and the frame abandoned (-1 = none).
  task automatic run_frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta,
                           input logic [15:0] wd, input int loc_at, input logic [4:0] la,
                           input logic [15:0] lw, input int rst_at, output logic [15:0] rx);
    logic        bits[$];
    logic        is_rd, is_wr, exp_fe, exp_wv, respond, aborted, e_oe, e_o;
    logic [15:0] rdv;
    int          wv0, fe0, oe0;

    bits = {};
    for (int i = 0; i < npre; i++) bits.push_back(1'b1);
    bits.push_back(st[1]); bits.push_back(st[0]);
    bits.push_back(op[1]); bits.push_back(op[0]);
    for (int i = 4; i >= 0; i--) bits.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
    bits.push_back(ta[1]); bits.push_back(ta[0]);
    for (int i = 15; i >= 0; i--) bits.push_back(wd[i]);
    bits.push_back(1'b0);

    // Frame-level outcome from the protocol rules.
    is_rd   = (op == 2'b10);
    is_wr   = (op == 2'b01);
    exp_fe  = 1'b0;
    exp_wv  = 1'b0;
    respond = 1'b0;
    if (npre >= PRE) begin
      if (st != 2'b01 || !(is_rd || is_wr)) exp_fe = 1'b1;
      else if (pa == PHY) begin
        if (is_rd)              respond = 1'b1;
        else if (ta != 2'b10)   exp_fe  = 1'b1;
        else                    exp_wv  = 1'b1;
      end
    end
    rdv = rd_model(ra);

    wv0 = wv_cnt; fe0 = fe_cnt; oe0 = oe_cyc;
    rx = 16'h0000;
    aborted = 1'b0;

    for (int i = 0; i < bits.size(); i++) begin
      mdd_i = bits[i];
      #40;
      // What the initiator sees at this MDC rising edge: turnaround 0 at TA bit 2,
      // then register bits 15..0 at data bits 15..0.
      e_oe = respond && (i >= npre + 15) && (i <= npre + 31);
      e_o  = (respond && (i >= npre + 16) && (i <= npre + 31)) ? rdv[31 - i + npre] : 1'b0;
      check("mdd_oe_at_mdc", {31'd0, mdd_oe}, {31'd0, e_oe});
      check("mdd_o_at_mdc",  {31'd0, mdd_o},  {31'd0, e_o});
      if (respond && (i >= npre + 16) && (i <= npre + 31)) rx = {rx[14:0], mdd_o};
      mdc_i = 1'b1;
      if (i == rst_at) begin
        #5 RST_N = 1'b0;
        #1;
        check("rst_mdd_oe_async", {31'd0, mdd_oe}, 32'd0);
        check("rst_mdd_o_async",  {31'd0, mdd_o},  32'd0);
        mdc_i   = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (i == loc_at) begin
        // Local strobe straddles the CLK edge where the MDIO write commits.
        #18;
        loc_we = 1'b1; loc_addr = la; loc_wdata = lw;
        #10;
        loc_we = 1'b0;
        #12;
      end else begin
        #40;
      end
      mdc_i = 1'b0;
    end

    if (!aborted) begin
      #20;
      check("wr_valid_pulses", wv_cnt - wv0, {31'd0, exp_wv});
      check("frame_err_pulses", fe_cnt - fe0, {31'd0, exp_fe});
      check("mdd_oe_clk_cycles", oe_cyc - oe0, respond ? 32'd136 : 32'd0);
      if (exp_wv) begin
        check("wr_addr", {27'd0, wa_cap}, {27'd0, ra});
        check("wr_data", {16'd0, wd_cap}, {16'd0, wd});
      end
      if (loc_at >= 0 && la != 5'd2 && la != 5'd3) model_reg[la] = lw;
      if (exp_wv && ra != 5'd2 && ra != 5'd3)       model_reg[ra] = wd;
    end
  endtask

  task automatic mdio_read(input int npre, input logic [4:0] pa, input logic [4:0] ra,
                           output logic [15:0] rx);
    run_frame(npre, 2'b01, 2'b10, pa, ra, 2'b11, 16'hFFFF, -1, 5'd0, 16'h0, -1, rx);
  endtask

  task automatic mdio_write(input logic [4:0] ra, input logic [15:0] wd);
    logic [15:0] rx;
    run_frame(PRE, 2'b01, 2'b01, PHY, ra, 2'b10, wd, -1, 5'd0, 16'h0, -1, rx);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mdd_oe"},    {31'd0, mdd_oe},    32'd0);
    check({tag, "_mdd_o"},     {31'd0, mdd_o},     32'd0);
    check({tag, "_wr_valid"},  {31'd0, wr_valid},  32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_wr_addr"},   {27'd0, wr_addr},   32'd0);
    check({tag, "_wr_data"},   {16'd0, wr_data},   32'd0);
  endtask

  initial begin
    logic [15:0] rx;
    for (int i = 0; i < 32; i++) model_reg[i] = 16'h0000;

    #22;
    check_reset_outputs("reset");
    @(negedge CLK) RST_N = 1'b1;
    @(negedge CLK) #2;

    // Write then read back a plain register.
    mdio_write(5'd4, 16'hA5C3);
    check("lit_wr_data_reg4", {16'd0, wd_cap}, 32'h0000A5C3);
    mdio_read(PRE, PHY, 5'd4, rx);
    check("lit_read_reg4", {16'd0, rx}, 32'h0000A5C3);

    // Identifier registers and their write protection.
    mdio_read(PRE, PHY, 5'd2, rx);
    check("lit_read_phyid1", {16'd0, rx}, 32'h00000022);
    mdio_read(PRE, PHY, 5'd3, rx);
    check("lit_read_phyid2", {16'd0, rx}, 32'h00005F10);
    mdio_write(5'd2, 16'hFFFF);
    check("lit_wr_addr_reg2", {27'd0, wa_cap}, 32'd2);
    mdio_read(PRE, PHY, 5'd2, rx);
    check("lit_reread_phyid1", {16'd0, rx}, 32'h00000022);

    // Short preamble, bad start, bad opcode, bad write turnaround.
    mdio_read(PRE - 1, PHY, 5'd2, rx);
    run_frame(PRE, 2'b00, 2'b10, PHY, 5'd2, 2'b11, 16'hFFFF, -1, 5'd0, 16'h0, -1, rx);
    run_frame(PRE, 2'b01, 2'b11, PHY, 5'd4, 2'b11, 16'hFFFF, -1, 5'd0, 16'h0, -1, rx);
    run_frame(PRE, 2'b01, 2'b01, PHY, 5'd4, 2'b11, 16'h1234, -1, 5'd0, 16'h0, -1, rx);

    // Foreign PHY address, then a normal read right after the skipped frame.
    mdio_read(PRE, 5'd7, 5'd4, rx);
    mdio_read(PRE, PHY, 5'd4, rx);
    check("lit_read_after_skip", {16'd0, rx}, 32'h0000A5C3);

    // Local write colliding with MDIO write completion.
    run_frame(PRE, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h2222, PRE + 31, 5'd5, 16'h1111, -1, rx);
    mdio_read(PRE, PHY, 5'd5, rx);
    check("lit_collide_same_addr", {16'd0, rx}, 32'h00002222);
    run_frame(PRE, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h2222, PRE + 31, 5'd6, 16'h1111, -1, rx);
    mdio_read(PRE, PHY, 5'd6, rx);
    check("lit_collide_other_addr", {16'd0, rx}, 32'h00001111);
    mdio_read(PRE, PHY, 5'd5, rx);
    check("lit_collide_mdio_kept", {16'd0, rx}, 32'h00002222);

    // Reset in the middle of read data bit 8, then a fresh frame.
    run_frame(PRE, 2'b01, 2'b10, PHY, 5'd4, 2'b11, 16'hFFFF, -1, 5'd0, 16'h0, PRE + 16 + 7, rx);
    #50;
    check_reset_outputs("midread_reset");
    for (int i = 0; i < 32; i++) model_reg[i] = 16'h0000;
    @(negedge CLK) RST_N = 1'b1;
    @(negedge CLK) #2;
    mdio_read(PRE, PHY, 5'd4, rx);
    check("lit_reg4_after_reset", {16'd0, rx}, 32'h00000000);
    mdio_read(PRE, PHY, 5'd3, rx);
    check("lit_phyid2_after_reset", {16'd0, rx}, 32'h00005F10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
